// File: rtl/sio_pkg.sv
// Shared serial-lane framing definitions used by both the transmitter and the matching receiver.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package sio_pkg;

    localparam int          HDR_W       = 8;
    localparam logic [7:0]  HDR_PAYLOAD = 8'hA5;
    localparam logic [7:0]  HDR_IDLE    = 8'h5A;

    typedef enum logic [1:0] {
        ST_RST,
        ST_LOAD,
        ST_SHIFT
    } tx_state_e;

    // Header selects between a frame carrying a FIFO word and an idle filler frame.
    function automatic logic [HDR_W-1:0] frame_hdr(input logic is_payload);
        return is_payload ? HDR_PAYLOAD : HDR_IDLE;
    endfunction

endpackage

// File: rtl/sio_fifo.sv
// Generic synchronous FIFO with registered occupancy count and head-of-queue read data.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; reset discards all contents.
module sio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sio_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i && !full_o && !rst_i;
    assign pop_ok    = pop_i && !empty_o && !rst_i;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and count; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sio_lane_tx.sv
// Serialises back-to-back frames {header, stream word, payload} MSB first across LANES outputs.
// Latency: first header bits appear on sdo one cycle after the load cycle; frames never gap.
// Backpressure: wready = write FIFO not full; an empty FIFO at load time sends an idle frame.
module sio_lane_tx
    import sio_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int PAYLOAD_W = 80,
    parameter int STREAM_W  = 16,
    parameter int DEPTH     = 4
) (
    input  logic                  c,
    input  logic                  r,
    input  logic [PAYLOAD_W-1:0]  wdata,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [STREAM_W-1:0]   stream_in,
    output logic [LANES-1:0]      sdo,
    output logic                  frame_start,
    output logic [15:0]           frames,
    output logic [15:0]           writes
);

    localparam int FRAME_BITS = HDR_W + STREAM_W + PAYLOAD_W;
    localparam int FCYC       = FRAME_BITS / LANES;
    localparam int CW         = (FCYC > 1) ? $clog2(FCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(FCYC - 1);

    if ((FRAME_BITS % LANES) != 0) begin : g_bad_lanes
        $error("sio_lane_tx: frame length must be a multiple of LANES");
    end

    tx_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic                    fs_q;
    logic [15:0]             frames_q, frames_d;
    logic [15:0]             writes_q, writes_d;
    logic                    load, pop;
    logic [PAYLOAD_W-1:0]    fifo_dat, payload;
    logic                    fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_cnt_unused;

    sio_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (c),
        .rst_i      (r),
        .push_i     (wvalid),
        .push_dat_i (wdata),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt_unused)
    );

    assign wready      = !fifo_full;
    assign sdo         = sh_q[FRAME_BITS-1 -: LANES];
    assign frame_start = fs_q;
    assign frames      = frames_q;
    assign writes      = writes_q;

    // State register: reset parks in RST, released reset passes through LOAD once.
    always_ff @(posedge c) begin
        if (r) state_q <= ST_RST;
        else   state_q <= state_d;
    end

    // Next state and load strobe: load once after reset, then at the last bit of every frame.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_RST:   state_d = ST_LOAD;
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: load = (cnt_q == LAST);
            default:  state_d = ST_RST;
        endcase
    end

    // Frame assembly: the head word is used only if it was already in the FIFO before this load.
    always_comb begin
        pop      = load && !fifo_empty;
        payload  = pop ? fifo_dat : '0;
        sh_d     = load ? {frame_hdr(pop), stream_in, payload} : (sh_q << LANES);
        cnt_d    = (state_q == ST_SHIFT && !load) ? cnt_q + 1'b1 : '0;
        frames_d = frames_q + 16'(load);
        writes_d = writes_q + 16'(pop);
    end

    // Datapath registers: reset clears the shifter so an aborted frame drives no further bits.
    always_ff @(posedge c) begin
        if (r) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            fs_q     <= 1'b0;
            frames_q <= '0;
            writes_q <= '0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            fs_q     <= load;
            frames_q <= frames_d;
            writes_q <= writes_d;
        end
    end

endmodule

// File: tb/tb_sio_lane_tx.sv
// Directed bench for sio_lane_tx: a default-parameter instance and a 4-lane instance.
// Latency: n/a.
// Backpressure: exercised through the write FIFO full/refill sequence.
module tb_sio_lane_tx;

    typedef logic [103:0] frame_t;

    logic         c = 1'b0;
    logic         r;
    logic [15:0]  stream;
    logic [79:0]  a_wdata, b_wdata;
    logic         a_wvalid, b_wvalid;
    logic         a_wready, b_wready;
    logic [0:0]   a_sdo;
    logic [3:0]   b_sdo;
    logic         a_fs, b_fs;
    logic [15:0]  a_frames, a_writes, b_frames, b_writes;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 c = ~c;

    sio_lane_tx dut_a (
        .c(c), .r(r), .wdata(a_wdata), .wvalid(a_wvalid), .wready(a_wready),
        .stream_in(stream), .sdo(a_sdo), .frame_start(a_fs),
        .frames(a_frames), .writes(a_writes)
    );

    sio_lane_tx #(.LANES(4)) dut_b (
        .c(c), .r(r), .wdata(b_wdata), .wvalid(b_wvalid), .wready(b_wready),
        .stream_in(stream), .sdo(b_sdo), .frame_start(b_fs),
        .frames(b_frames), .writes(b_writes)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Frame capture on the falling edge: frames restart on frame_start, reset drops partial frames.
    frame_t a_cur, b_cur;
    frame_t a_q[$];
    frame_t b_q[$];
    int a_n = 0, b_n = 0, a_since = 0, a_gap = 0;

    always @(negedge c) begin
        if (r) begin
            a_n = 0; a_since = 0;
        end else if (a_fs) begin
            a_gap = a_since; a_since = 1;
            a_cur = {103'd0, a_sdo}; a_n = 1;
        end else begin
            a_since++;
            if (a_n > 0) begin a_cur = {a_cur[102:0], a_sdo}; a_n++; end
        end
        if (a_n == 104) begin a_q.push_back(a_cur); a_n = 0; end
    end

    always @(negedge c) begin
        if (r) begin
            b_n = 0;
        end else if (b_fs) begin
            b_cur = {100'd0, b_sdo}; b_n = 1;
        end else if (b_n > 0) begin
            b_cur = {b_cur[99:0], b_sdo}; b_n++;
        end
        if (b_n == 26) begin b_q.push_back(b_cur); b_n = 0; end
    end

    task automatic wait_fs();
        for (int i = 0; i < 300; i++) begin
            @(negedge c);
            if (a_fs) break;
        end
        check("fs_wait", 128'(a_fs), 128'(1));
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < 3000; i++) begin
            @(posedge c);
            if (a_q.size() >= k) break;
        end
        @(negedge c);
        check("frames_wait", 128'(a_q.size() >= k), 128'(1));
    endtask

    localparam logic [79:0] PAY_B = 80'h1234_5678_9ABC_DEF0_CAFE;
    localparam logic [79:0] PAY_D1 = 80'h0F0F_0000_1111_2222_3333;
    logic [79:0] w_tab [5];
    int base, n;

    initial begin
        w_tab[0] = 80'h8000_0000_0000_0000_0001;
        w_tab[1] = 80'h0123_4567_89AB_CDEF_0F0F;
        w_tab[2] = 80'hFFFF_0000_FFFF_0000_FFFF;
        w_tab[3] = 80'h5555_AAAA_5555_AAAA_5555;
        w_tab[4] = 80'hDEAD_BEEF_0000_1111_2222;

        r = 1'b1; stream = 16'hBE00;
        a_wvalid = 1'b0; a_wdata = '0; b_wvalid = 1'b0; b_wdata = '0;
        repeat (2) @(negedge c);
        // A write offered during reset must be dropped.
        a_wvalid = 1'b1; a_wdata = '1;
        @(negedge c);
        check("rst_sdo",    128'(a_sdo),    128'(0));
        check("rst_fs",     128'(a_fs),     128'(0));
        check("rst_frames", 128'(a_frames), 128'(0));
        check("rst_writes", 128'(a_writes), 128'(0));
        check("rst_wready", 128'(a_wready), 128'(1));
        check("rst_b_sdo",  128'(b_sdo),    128'(0));
        a_wvalid = 1'b0;

        // Release: RST cycle, LOAD cycle, then first bits.
        r = 1'b0; b_wvalid = 1'b1; b_wdata = PAY_B;
        @(negedge c);
        b_wvalid = 1'b0;
        check("fs_lat1", 128'(a_fs), 128'(0));
        @(negedge c);
        check("fs_lat2",   128'(a_fs),     128'(1));
        check("frames1",   128'(a_frames), 128'(1));
        check("writes0",   128'(a_writes), 128'(0));
        check("b_frames1", 128'(b_frames), 128'(1));
        check("b_writes1", 128'(b_writes), 128'(1));
        check("a_bit0",    128'(a_sdo),    128'(0));
        check("b_nib0",    128'(b_sdo),    128'(4'hA));
        @(negedge c);
        check("a_bit1",    128'(a_sdo),    128'(1));
        check("b_nib1",    128'(b_sdo),    128'(4'h5));

        wait_frames(1);
        check("idle_frame0", 128'(a_q[0]), 128'({8'h5A, 16'hBE00, 80'h0}));
        check("b_frame_cnt", 128'(b_q.size() >= 1), 128'(1));
        check("b_frame0",    128'(b_q[0]), 128'({8'hA5, 16'hBE00, PAY_B}));
        @(negedge c);
        check("frame_period", 128'(a_gap), 128'(104));

        // Push in the load cycle with an empty FIFO: current frame idle, next carries the word.
        wait_fs();
        repeat (103) @(negedge c);
        a_wvalid = 1'b1; a_wdata = PAY_D1;
        check("ld_wready", 128'(a_wready), 128'(1));
        @(negedge c);
        a_wvalid = 1'b0;
        check("ld_edge_fs", 128'(a_fs), 128'(1));
        base = a_q.size();
        wait_frames(base + 2);
        check("ld_push_idle", 128'(a_q[base]),     128'({8'h5A, 16'hBE00, 80'h0}));
        check("ld_push_next", 128'(a_q[base + 1]), 128'({8'hA5, 16'hBE00, PAY_D1}));
        check("writes_d1",    128'(a_writes),      128'(1));

        // Overfill: four pushes fill the FIFO, the fifth waits for the next pop.
        stream = 16'h1357;
        wait_fs();
        base = a_q.size();
        for (int i = 0; i < 4; i++) begin
            a_wdata = w_tab[i]; a_wvalid = 1'b1;
            check("push_rdy", 128'(a_wready), 128'(1));
            @(negedge c);
        end
        check("full", 128'(a_wready), 128'(0));
        a_wdata = w_tab[4];
        n = 0;
        while (!a_wready && n < 300) begin
            @(negedge c);
            n++;
        end
        check("pop_frees", 128'(a_fs), 128'(1));
        @(negedge c);
        a_wvalid = 1'b0;
        check("refull", 128'(a_wready), 128'(0));
        wait_frames(base + 6);
        check("ovf_idle", 128'(a_q[base]), 128'({8'h5A, 16'h1357, 80'h0}));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_order%0d", i), 128'(a_q[base + 1 + i]),
                  128'({8'hA5, 16'h1357, w_tab[i]}));
        end
        check("writes6", 128'(a_writes), 128'(6));

        // Frame counter wrap from a preloaded all-ones value.
        repeat (3) @(negedge c);
        force dut_a.frames_q = 16'hFFFF;
        #1;
        release dut_a.frames_q;
        check("preload", 128'(a_frames), 128'(16'hFFFF));
        wait_fs();
        check("frames_wrap", 128'(a_frames), 128'(0));
        check("writes_hold", 128'(a_writes), 128'(6));

        // Reset mid payload frame: abort at once and flush the queued word.
        a_wdata = '1; a_wvalid = 1'b1;
        @(negedge c);
        a_wdata = PAY_D1;
        @(negedge c);
        a_wvalid = 1'b0;
        wait_fs();
        repeat (50) @(negedge c);
        check("bit50", 128'(a_sdo), 128'(1));
        r = 1'b1;
        @(negedge c);
        check("abort_sdo",    128'(a_sdo),    128'(0));
        check("abort_frames", 128'(a_frames), 128'(0));
        check("abort_writes", 128'(a_writes), 128'(0));
        check("abort_fs",     128'(a_fs),     128'(0));
        check("abort_wready", 128'(a_wready), 128'(1));
        @(negedge c);
        r = 1'b0;
        base = a_q.size();
        wait_fs();
        wait_frames(base + 1);
        check("flush_idle",   128'(a_q[base]), 128'({8'h5A, 16'h1357, 80'h0}));
        check("flush_writes", 128'(a_writes),  128'(0));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
